// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 style fetch path: sequencer state
// encoding, opcode width and the halt opcode.
package sap1_pkg;

  localparam int OPCODE_W = 4;
  localparam logic [OPCODE_W-1:0] HLT_OPCODE = 4'hF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    T1_ADDR = 3'd1,
    T2_INC  = 3'd2,
    T3_LOAD = 3'd3,
    EXEC    = 3'd4,
    HALT    = 3'd5
  } state_t;

endpackage

// File: rtl/program_counter.sv
// Program counter: increments modulo 2**AddressWidth (15 -> 0 wraps
// silently), optional parallel load, asynchronous active-low clear.
// Load has priority over increment.
module program_counter #(
  parameter int AddressWidth = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_inc,
  input  logic                    i_load,
  input  logic [AddressWidth-1:0] i_load_addr,
  output logic [AddressWidth-1:0] o_pc
);

  localparam logic [AddressWidth-1:0] PC_ONE = {{(AddressWidth-1){1'b0}}, 1'b1};

  logic [AddressWidth-1:0] r_pc;

  // Counter register: clear, load or increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc <= '0;
    end else if (i_load) begin
      r_pc <= i_load_addr;
    end else if (i_inc) begin
      r_pc <= r_pc + PC_ONE;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: IDLE -> T1_ADDR -> T2_INC -> T3_LOAD -> EXEC,
// or HALT when the captured opcode is HLT. Optional feature macro:
// FETCH_JUMP_EN adds i_jump / i_jump_addr, which reload the PC in EXEC.
//
// Handshake: o_ir_valid=1 means o_ir holds an unconsumed instruction and
// stays high with o_ir stable until the execute stage answers with
// i_exec_done=1 (ready); the transfer completes on the edge where both are 1.
// i_exec_done is ignored whenever o_ir_valid is 0.
module fetch_sequencer
  import sap1_pkg::*;
#(
  parameter int AddressWidth = 4,
  parameter int WordWidth    = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_run,
  input  logic [WordWidth-1:0]    i_word,
  input  logic                    i_exec_done,
`ifdef FETCH_JUMP_EN
  input  logic                    i_jump,
  input  logic [AddressWidth-1:0] i_jump_addr,
`endif
  output logic [AddressWidth-1:0] o_mar,
  output logic                    o_er,
  output logic [WordWidth-1:0]    o_ir,
  output logic [OPCODE_W-1:0]     o_opcode,
  output logic [AddressWidth-1:0] o_operand,
  output logic                    o_ir_valid,
  output logic [AddressWidth-1:0] o_pc,
  output logic                    o_halted
);

  state_t                  r_state;
  state_t                  w_next_state;
  logic [AddressWidth-1:0] r_mar;
  logic [WordWidth-1:0]    r_ir;
  logic                    r_er;
  logic                    r_ir_valid;
  logic                    r_halted;
  logic [AddressWidth-1:0] w_pc;
  logic                    w_pc_inc;
  logic                    w_pc_load;
  logic [AddressWidth-1:0] w_pc_load_addr;
  logic                    w_hlt_word;

  assign w_hlt_word = (i_word[WordWidth-1 -: OPCODE_W] == HLT_OPCODE);
  assign w_pc_inc   = (r_state == T2_INC);

`ifdef FETCH_JUMP_EN
  // A jump taken together with i_exec_done lands in the PC before T1_ADDR
  // copies it to the MAR, so the next fetch reads the jump target.
  assign w_pc_load      = (r_state == EXEC) && i_jump;
  assign w_pc_load_addr = i_jump_addr;
`else
  assign w_pc_load      = 1'b0;
  assign w_pc_load_addr = '0;
`endif

  program_counter #(
    .AddressWidth(AddressWidth)
  ) u_pc (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_inc      (w_pc_inc),
    .i_load     (w_pc_load),
    .i_load_addr(w_pc_load_addr),
    .o_pc       (w_pc)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; once a fetch starts it runs to EXEC regardless of i_run.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (i_run) w_next_state = T1_ADDR;
      T1_ADDR: w_next_state = T2_INC;
      T2_INC:  w_next_state = T3_LOAD;
      T3_LOAD: w_next_state = w_hlt_word ? HALT : EXEC;
      EXEC:    if (i_exec_done) w_next_state = i_run ? T1_ADDR : IDLE;
      HALT:    w_next_state = HALT;
      default: w_next_state = IDLE;
    endcase
  end

  // Registered datapath and status outputs, decoded from the next state so
  // that o_er is glitch-free and covers exactly T2_INC and T3_LOAD.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mar      <= '0;
      r_ir       <= '0;
      r_er       <= 1'b0;
      r_ir_valid <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_er       <= (w_next_state == T2_INC) || (w_next_state == T3_LOAD);
      r_ir_valid <= (w_next_state == EXEC);
      r_halted   <= (w_next_state == HALT);
      if (r_state == T1_ADDR) r_mar <= w_pc;
      if (r_state == T3_LOAD) r_ir <= i_word;
    end
  end

  assign o_mar      = r_mar;
  assign o_er       = r_er;
  assign o_ir       = r_ir;
  assign o_opcode   = r_ir[WordWidth-1 -: OPCODE_W];
  assign o_operand  = r_ir[AddressWidth-1:0];
  assign o_ir_valid = r_ir_valid;
  assign o_pc       = w_pc;
  assign o_halted   = r_halted;

endmodule
